// File: rtl/rf_wport_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter: default widths,
// write-source codes and the trace-view state encoding.
package rf_wport_arbiter_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  localparam logic RF_SRC_WB  = 1'b0;
  localparam logic RF_SRC_LLU = 1'b1;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_EMPTY = 2'd0;
  localparam arb_state_t ST_WAIT  = 2'd1;
  localparam arb_state_t ST_FORCE = 2'd2;

endpackage

// File: rtl/rf_wbuf_slot.sv
// One-entry holding register for an LLU result. A load in the same cycle as a
// drain wins, so the slot refills without a bubble.
module rf_wbuf_slot #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              drain,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Slot occupancy and payload
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      addr  <= {ADDR_W{1'b0}};
      data  <= {DATA_W{1'b0}};
    end else if (load) begin
      valid <= 1'b1;
      addr  <= in_addr;
      data  <= in_data;
    end else if (drain) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single register-file write port between WB (default owner)
// and a buffered long-latency-unit result with a bounded starvation wait.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_valid,
  input  logic              wb_w_en,
  input  logic [ADDR_W-1:0] wb_w_addr,
  input  logic [DATA_W-1:0] wb_w_data,
  output logic              wb_ready,
  input  logic              llu_valid,
  input  logic [ADDR_W-1:0] llu_w_addr,
  input  logic [DATA_W-1:0] llu_w_data,
  output logic              llu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_src,
  output logic              llu_pend_valid,
  output logic [ADDR_W-1:0] llu_pend_addr
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic              buf_valid_s;
  logic [ADDR_W-1:0] buf_addr_s;
  logic [DATA_W-1:0] buf_data_s;
  logic [3:0]        starve_cnt_r;
  arb_state_t        state_s;
  logic              wb_req_s;
  logic              llu_grant_s;
  logic              wb_grant_s;
  logic              capture_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;

  rf_wbuf_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
    .clk     (clk),
    .resetn  (resetn),
    .load    (capture_s),
    .drain   (llu_grant_s),
    .in_addr (llu_w_addr),
    .in_data (llu_w_data),
    .valid   (buf_valid_s),
    .addr    (buf_addr_s),
    .data    (buf_data_s)
  );

  // State is a pure decode of buffer occupancy and the starvation count
  always_comb begin
    if (!buf_valid_s) begin
      state_s = ST_EMPTY;
    end else if (starve_cnt_r == CNT_MAX) begin
      state_s = ST_FORCE;
    end else begin
      state_s = ST_WAIT;
    end
  end

  // Grant decision and handshakes
  always_comb begin
    wb_req_s = wb_valid & wb_w_en;
    case (state_s)
      ST_EMPTY: llu_grant_s = 1'b0;
      ST_WAIT:  llu_grant_s = ~wb_req_s;
      ST_FORCE: llu_grant_s = 1'b1;
      default:  llu_grant_s = 1'b0;
    endcase
    wb_grant_s = wb_req_s & ~llu_grant_s;
    llu_ready  = ~buf_valid_s | llu_grant_s;
    wb_ready   = ~(wb_req_s & llu_grant_s);
    capture_s  = llu_valid & llu_ready;
    if (llu_grant_s) begin
      sel_addr_s = buf_addr_s;
      sel_data_s = buf_data_s;
    end else begin
      sel_addr_s = wb_w_addr;
      sel_data_s = wb_w_data;
    end
  end

  // Counts WB grants taken while an LLU result sits in the buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_r <= 4'd0;
    end else if (llu_grant_s) begin
      starve_cnt_r <= 4'd0;
    end else if (buf_valid_s && wb_grant_s && (starve_cnt_r != CNT_MAX)) begin
      starve_cnt_r <= starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Registered write port; r0 writes are swallowed but still consume the grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= 1'b0;
      rf_waddr <= {ADDR_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
      rf_src   <= RF_SRC_WB;
    end else if (llu_grant_s || wb_grant_s) begin
      rf_we    <= (sel_addr_s != {ADDR_W{1'b0}});
      rf_waddr <= sel_addr_s;
      rf_wdata <= (sel_addr_s == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : sel_data_s;
      rf_src   <= llu_grant_s ? RF_SRC_LLU : RF_SRC_WB;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  assign llu_pend_valid = buf_valid_s;
  assign llu_pend_addr  = buf_addr_s;

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single register-file write port between the in-order WB stage and a long-latency unit (LLU: divider, CSR reads) that completes out of band. Sits between WB and the register file. Holds one LLU result in a buffer and grants the port to WB by default. Forces an LLU grant after a bounded wait so the LLU cannot starve. Exports the pending LLU destination so ID hazard logic can stall readers.

## Interface
- STARVE_MAX, 4: max cycles a buffered LLU result waits before a forced grant (1..15).
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- wb_valid  in  1  WB holds a valid instruction.
- wb_w_en  in  1  WB instruction writes the register file.
- wb_w_addr  in  ADDR_W  WB destination.
- wb_w_data  in  DATA_W  WB write data.
- wb_ready  out  1  WB may retire this cycle; drives WB ready_go.
- llu_valid  in  1  LLU result available.
- llu_w_addr  in  ADDR_W  LLU destination.
- llu_w_data  in  DATA_W  LLU result.
- llu_ready  out  1  LLU result accepted this cycle.
- rf_we  out  1  registered write enable.
- rf_waddr  out  ADDR_W  registered write address.
- rf_wdata  out  DATA_W  registered write data.
- rf_src  out  1  source of the current rf_* write: 0 = WB, 1 = LLU.
- llu_pend_valid  out  1  buffer holds an unwritten LLU result.
- llu_pend_addr  out  ADDR_W  destination of the buffered result.

## Operation
- WB requests the port only when wb_valid & wb_w_en. A WB instruction with wb_w_en=0 retires with wb_ready=1 and never consumes the port.
- LLU handshake: transfer when llu_valid & llu_ready. llu_ready = ~buf_valid | llu_grant, so the buffer refills in the same cycle it drains.
- States are decoded from buf_valid and starve_cnt:
  - EMPTY (buf_valid=0): WB is granted. EMPTY → WAIT on an LLU capture.
  - WAIT (buffer full, starve_cnt < STARVE_MAX): LLU is granted only when WB does not request. Otherwise WB is granted and starve_cnt increments.
  - FORCE (buffer full, starve_cnt == STARVE_MAX): LLU is granted. wb_ready = ~(wb_valid & wb_w_en).
- On an LLU grant:
  - starve_cnt clears to 0.
  - The next state is WAIT if a new result is captured in that same cycle, otherwise EMPTY.
- starve_cnt saturates at STARVE_MAX.
- rf_src and the rf_* registers load from the granted source. rf_we=0 on cycles with no grant.
- Writes to address 0: rf_we=0 and rf_wdata=0, but the grant is still consumed (handshake completes, counter clears).
- llu_pend_valid = buf_valid and llu_pend_addr = buffer address, both taken directly from the buffer registers.
- WAW ordering (older LLU result vs. newer WB write to the same register) is not resolved here. ID must stall on llu_pend_addr.

## Timing
- rf_* outputs appear one cycle after the granting edge.
- wb_ready and llu_ready are combinational from current inputs and state.
- Worst-case LLU wait from capture to grant: STARVE_MAX+1 cycles.
- WB stall per forced grant: exactly 1 cycle.
- Reset (async, any time, including mid-FORCE):
  - buf_valid, starve_cnt, rf_we, rf_src, rf_waddr, rf_wdata, llu_pend_valid and llu_pend_addr all go to 0.
  - The buffered result is discarded.
  - While resetn=0, llu_ready=1 and wb_ready=1, but no state is captured.
- On the first edge after release, state is EMPTY.

## Structure
- Shared package holds:
  - ADDR_W and DATA_W defaults.
  - RF_SRC_WB=1'b0, RF_SRC_LLU=1'b1.
  - State encoding EMPTY=2'd0, WAIT=2'd1, FORCE=2'd2, for the debug/trace view.
- One natural sub-module: rf_wbuf_slot, the one-entry valid/addr/data holding register with simultaneous drain/refill.

## Test plan
- WB-only stream: writes to r1..r4 with data 0x11..0x44 → rf_we=1, rf_src=0, writes appear one cycle after each; wb_ready stays 1.
- LLU result r7=0xDEAD while WB is idle → captured, granted the next cycle; rf_waddr=7, rf_wdata=0xDEAD, rf_src=1; llu_pend_valid high for exactly 1 cycle.
- LLU result r9 under continuous WB writes, STARVE_MAX=4:
  - WB is granted 4 cycles, then FORCE.
  - wb_ready=0 for 1 cycle and r9 is written.
  - starve_cnt returns to 0.
- Back-to-back LLU results r5 and r6 under WB idle → llu_ready stays 1 and writes land on consecutive cycles via same-cycle refill.
- Address-0 writes from each source with data 0xFFFF_FFFF → rf_we=0, rf_wdata=0; the LLU buffer empties.
- Reset asserted mid-FORCE with the buffer full → all outputs 0 immediately; after release a WB write to r3 passes with wb_ready=1.
